oq_rr_scheduler: RTL
====================

// Module: oq_rr_scheduler
// PURPOSE
//  Packet-granular round-robin scheduler for the SRAM output-queue read path.
//  Picks one output queue that has a stored packet and a ready destination port,
//  then drives read-beat requests for that queue to the SRAM read controller.
//  It holds the grant until the end-of-packet beat is accepted. Sits between the
//  per-queue occupancy logic and the SRAM read engine that produces dout/queue_id.
// PARAMETERS
//  NUM_QUEUES      5    number of output queues arbitrated (2..8)
//  QUEUE_ID_WIDTH  3    width of queue index; 2**QUEUE_ID_WIDTH >= NUM_QUEUES
//  WDOG_CYCLES     256  stall limit in XFER, only used with OQ_SCHED_WATCHDOG_EN
// PORTS
//  memclk       in   1               single clock for the block
//  reset        in   1               asynchronous, active-high reset
//  oq_nonempty  in   NUM_QUEUES      bit i = queue i holds >=1 complete packet
//  dst_ready    in   NUM_QUEUES      bit i = destination port i can take data
//  rd_req       out  1               request one read beat for rd_queue_id
//  rd_queue_id  out  QUEUE_ID_WIDTH  queue currently granted
//  rd_ack       in   1               read controller accepted the beat this cycle
//  rd_last      in   1               accepted beat is end of packet (valid w/ rd_ack)
//  grant_valid  out  1               a packet grant is held (state XFER)
//  pkt_done     out  1               1-cycle pulse, packet of pkt_done_id finished
//  pkt_done_id  out  QUEUE_ID_WIDTH  queue whose packet finished
//  wdog_err     out  1               1-cycle pulse on watchdog abort (macro only)
// BEHAVIOUR
//  Reset (async assert, sync deassert by memclk): state=IDLE.
//   rd_req=0, rd_queue_id=0, grant_valid=0, pkt_done=0, pkt_done_id=0, wdog_err=0.
//   The RR pointer is reset so queue 0 has highest priority.
//  Eligibility: elig[i] = oq_nonempty[i] & dst_ready[i].
//  RR search starts at pointer ptr and checks ptr, ptr+1, .. NUM_QUEUES-1, then
//   wraps to 0 (mod NUM_QUEUES). The first eligible queue wins.
//  FSM, 2 states:
//   IDLE: if any elig at cycle N -> register winner into rd_queue_id and go to
//    XFER. At N+1: grant_valid=1 and rd_req=dst_ready[rd_queue_id].
//    No eligible queue -> stay in IDLE, outputs unchanged except rd_req=0.
//   XFER: rd_req = dst_ready[rd_queue_id], combinational. A dropped dst_ready
//    pauses requests; the grant is kept. The packet is never preempted.
//    A change of oq_nonempty for the granted queue is ignored while in XFER.
//    rd_ack&rd_last -> next cycle: state=IDLE, grant_valid=0, rd_req=0;
//    pkt_done=1 and pkt_done_id=granted queue; ptr=granted+1 (mod NUM_QUEUES).
//    rd_ack&~rd_last -> stay in XFER, count nothing.
//  Minimum one bubble cycle (IDLE) between packets, even with one eligible queue.
//  rd_ack while rd_req=0, or rd_last without rd_ack: ignored, no state change.
//  ptr wraps NUM_QUEUES-1 -> 0. rd_queue_id is never >= NUM_QUEUES.
//  Reset mid-XFER: the grant is dropped immediately (async). No pkt_done is issued.
//  pkt_done and wdog_err are never high in the same cycle.
// CONFIGURATION
//  OQ_SCHED_WATCHDOG_EN defined:
//   A counter in XFER increments each cycle without rd_ack and clears on rd_ack.
//   Reaching WDOG_CYCLES-1 aborts: next cycle state=IDLE, wdog_err=1 pulse, no
//   pkt_done, and ptr=granted+1.
//  Macro undefined: no counter; wdog_err tied 0; XFER waits indefinitely.
// TESTING
//  1 oq_nonempty=5'b00100, dst_ready=all 1 -> rd_req 1 cycle later, id=2;
//    3 acks, last on 3rd -> pkt_done id=2, then IDLE.
//  2 all 5 queues eligible from reset, 1-beat packets -> grant order 0,1,2,3,4,0.
//    Each grant is separated by exactly 1 IDLE cycle.
//  3 grant q1, drop dst_ready[1] for 4 cycles mid-packet -> rd_req=0 for those
//    cycles, grant_valid=1 and id=1 held, then resumes.
//  4 last grant q4, only q0 and q3 eligible -> next grant q0 (wrap).
//  5 assert reset mid-XFER -> all outputs 0 in the same cycle; after release
//    with all eligible -> first grant q0.
//  6 (OQ_SCHED_WATCHDOG_EN, WDOG_CYCLES=16) grant q2, never ack -> wdog_err
//    pulse 16 cycles after grant, IDLE, next grant starts at q3.

Source files
------------

// File: rtl/oq_rr_scheduler_if.sv
// oq_rr_scheduler_if: occupancy/ready inputs and SRAM read-beat handshake for the output-queue scheduler.
interface oq_rr_scheduler_if #(
   parameter int NUM_QUEUES     = 5,
   parameter int QUEUE_ID_WIDTH = 3
);
   logic [NUM_QUEUES-1:0]     oq_nonempty;
   logic [NUM_QUEUES-1:0]     dst_ready;
   logic                      rd_req;
   logic [QUEUE_ID_WIDTH-1:0] rd_queue_id;
   logic                      rd_ack;
   logic                      rd_last;
   logic                      grant_valid;
   logic                      pkt_done;
   logic [QUEUE_ID_WIDTH-1:0] pkt_done_id;
   logic                      wdog_err;
   modport master (
      input  oq_nonempty, dst_ready, rd_ack, rd_last,
      output rd_req, rd_queue_id, grant_valid, pkt_done, pkt_done_id, wdog_err
   );
   modport slave (
      output oq_nonempty, dst_ready, rd_ack, rd_last,
      input  rd_req, rd_queue_id, grant_valid, pkt_done, pkt_done_id, wdog_err
   );
endinterface

// File: rtl/oq_rr_scheduler.sv
// oq_rr_scheduler: packet-granular round-robin grant of output queues to the SRAM read engine.
// Optional stall watchdog in XFER is enabled by defining OQ_SCHED_WATCHDOG_EN.
module oq_rr_scheduler #(
   parameter int NUM_QUEUES     = 5,
   parameter int QUEUE_ID_WIDTH = 3,
   parameter int WDOG_CYCLES    = 256
) (
   input logic                 memclk,
   input logic                 reset,
   oq_rr_scheduler_if.master   bus
);
   typedef enum logic {IDLE, XFER} state_t;
   state_t                    state, state_nxt;
   logic [QUEUE_ID_WIDTH-1:0] ptr, ptr_nxt, qid, qid_nxt, winner, cand, pdid;
   logic [NUM_QUEUES-1:0]     elig;
   logic                      found, ack_ok, done, abort, pdone, werr;
   assign elig   = bus.oq_nonempty & bus.dst_ready;
   assign ack_ok = state == XFER && bus.dst_ready[qid] && bus.rd_ack;
   assign done   = ack_ok && bus.rd_last;
   // first eligible queue at or after ptr, wrapping modulo NUM_QUEUES
   always_comb begin
      winner = '0;
      cand   = '0;
      found  = 1'b0;
      for (int k = 0; k < NUM_QUEUES; k++) begin
         cand = QUEUE_ID_WIDTH'((int'(ptr) + k) % NUM_QUEUES);
         if (!found && elig[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end
`ifdef OQ_SCHED_WATCHDOG_EN
   localparam int CW = $clog2(WDOG_CYCLES);
   logic [CW-1:0] wcnt;
   assign abort = state == XFER && !ack_ok && wcnt == CW'(WDOG_CYCLES - 1);
   always_ff @(posedge memclk or posedge reset)
      if (reset) wcnt <= '0;
      else wcnt <= (state != XFER || ack_ok) ? '0 : wcnt + CW'(1);
`else
   assign abort = 1'b0;
`endif
   always_comb begin
      state_nxt = state;
      qid_nxt   = qid;
      ptr_nxt   = ptr;
      if (state == IDLE && found) begin
         state_nxt = XFER;
         qid_nxt   = winner;
      end
      if (done || abort) begin
         state_nxt = IDLE;
         ptr_nxt   = (int'(qid) == NUM_QUEUES - 1) ? '0 : qid + QUEUE_ID_WIDTH'(1);
      end
   end
   always_ff @(posedge memclk or posedge reset)
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
         qid   <= '0;
         pdone <= 1'b0;
         pdid  <= '0;
         werr  <= 1'b0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         qid   <= qid_nxt;
         pdone <= done;
         pdid  <= done ? qid : pdid;
         werr  <= abort;
      end
   assign bus.rd_req      = state == XFER && bus.dst_ready[qid];
   assign bus.rd_queue_id = qid;
   assign bus.grant_valid = state == XFER;
   assign bus.pkt_done    = pdone;
   assign bus.pkt_done_id = pdid;
   assign bus.wdog_err    = werr;
endmodule
